// File: rtl/reaction_round_sequencer_if.sv
`timescale 1ns/1ps
// Signal bundle between the reaction-round sequencer and its surroundings
// (button/start sources on one side, LED and score display on the other).
interface reaction_round_sequencer_if;
  logic       start;
  logic       button;
  logic       led_go;
  logic       busy;
  logic       done;
  logic       result_valid;
  logic [9:0] reaction_ms;
  logic       false_start;
  logic       timeout;
  logic [9:0] best_ms;
  logic [2:0] round_idx;

  modport master (
    output start, button,
    input  led_go, busy, done, result_valid, reaction_ms,
    input  false_start, timeout, best_ms, round_idx
  );

  modport slave (
    input  start, button,
    output led_go, busy, done, result_valid, reaction_ms,
    output false_start, timeout, best_ms, round_idx
  );
endinterface

// File: rtl/reaction_round_sequencer.sv
`timescale 1ns/1ps
// Reaction-game round sequencer: random hold-off, go LED, millisecond reaction
// timing with false-start/timeout flags and best-time tracking over a session.
module reaction_round_sequencer #(
  parameter int TICK_DIV  = 27000,
  parameter int MIN_WAIT  = 500,
  parameter int RAND_MASK = 1023,
  parameter int TIMEOUT   = 999,
  parameter int ROUNDS    = 5
) (
  input logic clk,
  input logic reset,
  reaction_round_sequencer_if.slave bus
);

  localparam int              PW         = $clog2(TICK_DIV);
  localparam logic [PW-1:0]   TICK_LAST  = PW'(TICK_DIV - 1);
  localparam logic [9:0]      MS_LIMIT   = 10'(TIMEOUT);
  localparam logic [2:0]      LAST_ROUND = 3'(ROUNDS - 1);
  localparam logic [10:0]     WAIT_BASE  = 11'(MIN_WAIT);
  localparam logic [9:0]      WAIT_MASK  = 10'(RAND_MASK);

  // IDLE: no session | ARM: wait for button release | WAIT: random hold-off
  // GO: LED lit, timing | REPORT: one-cycle result | DONE: session finished
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ARM    = 3'd1,
    S_WAIT   = 3'd2,
    S_GO     = 3'd3,
    S_REPORT = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t state, state_next;

  logic [15:0]   lfsr;
  logic          lfsr_fb;
  logic [PW-1:0] prescaler;
  logic          tick;
  logic          button_q;
  logic          press;
  logic          timer_restart;
  logic [10:0]   wait_load;

  logic [10:0] wait_cnt, wait_cnt_next;
  logic [9:0]  ms_cnt, ms_cnt_next;
  logic [9:0]  reaction_q, reaction_next;
  logic        false_q, false_next;
  logic        timeout_q, timeout_next;
  logic [9:0]  best_q, best_next;
  logic [2:0]  round_q, round_next;

  logic led_go_q, busy_q, done_q, result_valid_q;

  assign lfsr_fb       = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
  assign tick          = (prescaler == TICK_LAST);
  assign press         = bus.button & ~button_q;
  assign wait_load     = WAIT_BASE + {1'b0, lfsr[9:0] & WAIT_MASK};
  // Both timed states start from a fresh tick period on entry.
  assign timer_restart = (state_next != state) &&
                         ((state_next == S_WAIT) || (state_next == S_GO));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr      <= 16'hACE1;
      prescaler <= '0;
      button_q  <= 1'b0;
    end else begin
      lfsr     <= {lfsr[14:0], lfsr_fb};
      button_q <= bus.button;
      if (timer_restart || tick) prescaler <= '0;
      else                       prescaler <= prescaler + 1'b1;
    end
  end

  always_comb begin
    state_next    = state;
    wait_cnt_next = wait_cnt;
    ms_cnt_next   = ms_cnt;
    reaction_next = reaction_q;
    false_next    = false_q;
    timeout_next  = timeout_q;
    best_next     = best_q;
    round_next    = round_q;
    case (state)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          state_next = S_ARM;
          round_next = 3'd0;
        end
      end
      S_ARM: begin
        if (!bus.button) begin
          state_next    = S_WAIT;
          wait_cnt_next = wait_load;
        end
      end
      S_WAIT: begin
        if (press) begin
          state_next    = S_REPORT;
          false_next    = 1'b1;
          timeout_next  = 1'b0;
          reaction_next = 10'd0;
        end else if (tick) begin
          if (wait_cnt <= 11'd1) begin
            state_next  = S_GO;
            ms_cnt_next = 10'd0;
          end else begin
            wait_cnt_next = wait_cnt - 11'd1;
          end
        end
      end
      S_GO: begin
        if (press) begin
          state_next    = S_REPORT;
          reaction_next = ms_cnt;
          false_next    = 1'b0;
          timeout_next  = 1'b0;
        end else if (tick) begin
          if (ms_cnt == MS_LIMIT) begin
            state_next    = S_REPORT;
            reaction_next = MS_LIMIT;
            false_next    = 1'b0;
            timeout_next  = 1'b1;
          end else begin
            ms_cnt_next = ms_cnt + 10'd1;
          end
        end
      end
      S_REPORT: begin
        if (!false_q && !timeout_q && (reaction_q < best_q)) best_next = reaction_q;
        if (round_q == LAST_ROUND) begin
          state_next = S_DONE;
        end else begin
          state_next = S_ARM;
          round_next = round_q + 3'd1;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt       <= '0;
      ms_cnt         <= '0;
      reaction_q     <= '0;
      false_q        <= 1'b0;
      timeout_q      <= 1'b0;
      best_q         <= 10'h3FF;
      round_q        <= '0;
      led_go_q       <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      result_valid_q <= 1'b0;
    end else begin
      wait_cnt       <= wait_cnt_next;
      ms_cnt         <= ms_cnt_next;
      reaction_q     <= reaction_next;
      false_q        <= false_next;
      timeout_q      <= timeout_next;
      best_q         <= best_next;
      round_q        <= round_next;
      led_go_q       <= (state_next == S_GO);
      busy_q         <= (state_next == S_ARM) || (state_next == S_WAIT) ||
                        (state_next == S_GO)  || (state_next == S_REPORT);
      done_q         <= (state_next == S_DONE);
      result_valid_q <= (state_next == S_REPORT);
    end
  end

  assign bus.led_go       = led_go_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.result_valid = result_valid_q;
  assign bus.reaction_ms  = reaction_q;
  assign bus.false_start  = false_q;
  assign bus.timeout      = timeout_q;
  assign bus.best_ms      = best_q;
  assign bus.round_idx    = round_q;

endmodule

// File: tb/tb_reaction_round_sequencer.sv
`timescale 1ns/1ps
// Bench for reaction_round_sequencer: scoreboard of expected trial results plus
// per-scenario timing and best-time checks.
module tb_reaction_round_sequencer;

  localparam int TICK_DIV  = 4;
  localparam int MIN_WAIT  = 3;
  localparam int RAND_MASK = 0;
  localparam int TIMEOUT   = 20;
  localparam int ROUNDS    = 2;

  logic clk = 1'b0;
  logic reset;

  reaction_round_sequencer_if tb_if();

  reaction_round_sequencer #(
    .TICK_DIV(TICK_DIV), .MIN_WAIT(MIN_WAIT), .RAND_MASK(RAND_MASK),
    .TIMEOUT(TIMEOUT), .ROUNDS(ROUNDS)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(tb_if)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [9:0] r;
    logic       fs;
    logic       to;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;

  // Scoreboard: every REPORT cycle pops the oldest expected trial result.
  always @(negedge clk) begin
    if (reset === 1'b0 && tb_if.result_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL sb_unexpected: result_valid with nothing expected, reaction_ms=%0d", tb_if.reaction_ms);
      end else begin
        mon_e = sb_q.pop_front();
        n_checks++;
        if (tb_if.reaction_ms !== mon_e.r) begin
          n_fail++;
          $display("FAIL sb_reaction_ms: got %0d expected %0d", tb_if.reaction_ms, mon_e.r);
        end
        n_checks++;
        if (tb_if.false_start !== mon_e.fs) begin
          n_fail++;
          $display("FAIL sb_false_start: got %0b expected %0b", tb_if.false_start, mon_e.fs);
        end
        n_checks++;
        if (tb_if.timeout !== mon_e.to) begin
          n_fail++;
          $display("FAIL sb_timeout: got %0b expected %0b", tb_if.timeout, mon_e.to);
        end
      end
    end
  end

  function automatic exp_t mk(input int r, input bit fs, input bit to);
    exp_t e;
    e.r = 10'(r); e.fs = fs; e.to = to;
    return e;
  endfunction

  task automatic wait_led(output int cnt);
    cnt = 0;
    while (tb_if.led_go !== 1'b1 && cnt < 300) begin
      @(negedge clk);
      cnt++;
    end
  endtask

  task automatic wait_result(output int cnt);
    cnt = 0;
    while (tb_if.result_valid !== 1'b1 && cnt < 300) begin
      @(negedge clk);
      cnt++;
    end
  endtask

  task automatic press_at(input int k);
    repeat (k) @(negedge clk);
    tb_if.button = 1'b1;
    @(negedge clk);
    tb_if.button = 1'b0;
  endtask

  task automatic pulse_start();
    tb_if.start = 1'b1;
    @(negedge clk);
    tb_if.start = 1'b0;
  endtask

  task automatic test_reset();
    n_checks++;
    if ({tb_if.led_go, tb_if.busy, tb_if.done, tb_if.result_valid, tb_if.false_start, tb_if.timeout} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b expected 000000", {tb_if.led_go, tb_if.busy, tb_if.done, tb_if.result_valid, tb_if.false_start, tb_if.timeout});
    end
    n_checks++;
    if (tb_if.best_ms !== 10'h3FF || tb_if.reaction_ms !== 10'd0 || tb_if.round_idx !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_values: got best=%0h reaction=%0d round=%0d expected 3ff 0 0", tb_if.best_ms, tb_if.reaction_ms, tb_if.round_idx);
    end
  endtask

  task automatic test_nominal();
    int cnt;
    sb_q.push_back(mk(5, 0, 0));
    pulse_start();
    n_checks++;
    if (tb_if.busy !== 1'b1 || tb_if.round_idx !== 3'd0) begin
      n_fail++;
      $display("FAIL nominal_arm: got busy=%0b round=%0d expected 1 0", tb_if.busy, tb_if.round_idx);
    end
    wait_led(cnt);
    n_checks++;
    if (cnt !== 13) begin
      n_fail++;
      $display("FAIL nominal_go_delay: got %0d expected 13", cnt);
    end
    press_at(21);
    n_checks++;
    if (tb_if.result_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL nominal_report: got result_valid=%0b expected 1", tb_if.result_valid);
    end
    @(negedge clk);
    n_checks++;
    if (tb_if.best_ms !== 10'd5 || tb_if.round_idx !== 3'd1 || tb_if.result_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL nominal_best: got best=%0d round=%0d rv=%0b expected 5 1 0", tb_if.best_ms, tb_if.round_idx, tb_if.result_valid);
    end
  endtask

  task automatic test_timeout();
    int cnt;
    sb_q.push_back(mk(20, 0, 1));
    wait_led(cnt);
    n_checks++;
    if (cnt !== 13) begin
      n_fail++;
      $display("FAIL timeout_go_delay: got %0d expected 13", cnt);
    end
    wait_result(cnt);
    n_checks++;
    if (cnt !== 84) begin
      n_fail++;
      $display("FAIL timeout_len: got %0d expected 84", cnt);
    end
    @(negedge clk);
    n_checks++;
    if (tb_if.best_ms !== 10'd5 || tb_if.done !== 1'b1 || tb_if.round_idx !== 3'd1) begin
      n_fail++;
      $display("FAIL timeout_done: got best=%0d done=%0b round=%0d expected 5 1 1", tb_if.best_ms, tb_if.done, tb_if.round_idx);
    end
  endtask

  task automatic test_false_start();
    int cnt;
    bit led_seen;
    led_seen = 1'b0;
    sb_q.push_back(mk(0, 1, 0));
    pulse_start();
    n_checks++;
    if (tb_if.round_idx !== 3'd0) begin
      n_fail++;
      $display("FAIL fs_round_clear: got %0d expected 0", tb_if.round_idx);
    end
    repeat (6) begin
      @(negedge clk);
      if (tb_if.led_go === 1'b1) led_seen = 1'b1;
    end
    tb_if.button = 1'b1;
    @(negedge clk);
    tb_if.button = 1'b0;
    if (tb_if.led_go === 1'b1) led_seen = 1'b1;
    n_checks++;
    if (led_seen || tb_if.result_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL fs_report: got led_seen=%0b rv=%0b expected 0 1", led_seen, tb_if.result_valid);
    end
    @(negedge clk);
    n_checks++;
    if (tb_if.best_ms !== 10'd5 || tb_if.round_idx !== 3'd1) begin
      n_fail++;
      $display("FAIL fs_best: got best=%0d round=%0d expected 5 1", tb_if.best_ms, tb_if.round_idx);
    end
    sb_q.push_back(mk(10, 0, 0));
    wait_led(cnt);
    press_at(40);
    @(negedge clk);
    n_checks++;
    if (tb_if.done !== 1'b1 || tb_if.best_ms !== 10'd5 || tb_if.false_start !== 1'b0) begin
      n_fail++;
      $display("FAIL fs_session_end: got done=%0b best=%0d fs=%0b expected 1 5 0", tb_if.done, tb_if.best_ms, tb_if.false_start);
    end
  endtask

  task automatic test_session_best();
    int cnt;
    sb_q.push_back(mk(7, 0, 0));
    pulse_start();
    wait_led(cnt);
    press_at(29);
    @(negedge clk);
    n_checks++;
    if (tb_if.best_ms !== 10'd5) begin
      n_fail++;
      $display("FAIL best_keep: got %0d expected 5", tb_if.best_ms);
    end
    sb_q.push_back(mk(2, 0, 0));
    wait_led(cnt);
    n_checks++;
    if (cnt !== 13) begin
      n_fail++;
      $display("FAIL best_go_delay: got %0d expected 13", cnt);
    end
    press_at(9);
    @(negedge clk);
    n_checks++;
    if (tb_if.best_ms !== 10'd2 || tb_if.done !== 1'b1 || tb_if.round_idx !== 3'd1 || tb_if.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL best_update: got best=%0d done=%0b round=%0d busy=%0b expected 2 1 1 0", tb_if.best_ms, tb_if.done, tb_if.round_idx, tb_if.busy);
    end
  endtask

  task automatic test_busy_start();
    int cnt;
    sb_q.push_back(mk(0, 0, 0));
    pulse_start();
    n_checks++;
    if (tb_if.round_idx !== 3'd0 || tb_if.best_ms !== 10'd2) begin
      n_fail++;
      $display("FAIL restart: got round=%0d best=%0d expected 0 2", tb_if.round_idx, tb_if.best_ms);
    end
    repeat (4) @(negedge clk);
    pulse_start();
    wait_led(cnt);
    n_checks++;
    if (cnt !== 8 || tb_if.round_idx !== 3'd0) begin
      n_fail++;
      $display("FAIL busy_start_ignored: got delay=%0d round=%0d expected 8 0", cnt, tb_if.round_idx);
    end
    press_at(3);
    @(negedge clk);
    n_checks++;
    if (tb_if.best_ms !== 10'd0 || tb_if.round_idx !== 3'd1) begin
      n_fail++;
      $display("FAIL tick_press_best: got best=%0d round=%0d expected 0 1", tb_if.best_ms, tb_if.round_idx);
    end
    sb_q.push_back(mk(1, 0, 0));
    wait_led(cnt);
    repeat (7) @(negedge clk);
    tb_if.button = 1'b1;
    @(negedge clk);
    n_checks++;
    if (tb_if.result_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL held_press_report: got rv=%0b expected 1", tb_if.result_valid);
    end
    @(negedge clk);
    n_checks++;
    if (tb_if.done !== 1'b1 || tb_if.best_ms !== 10'd0) begin
      n_fail++;
      $display("FAIL busy_session_end: got done=%0b best=%0d expected 1 0", tb_if.done, tb_if.best_ms);
    end
  endtask

  task automatic test_held_button();
    int cnt;
    bit seen;
    seen = 1'b0;
    sb_q.push_back(mk(20, 0, 1));
    pulse_start();
    repeat (10) begin
      @(negedge clk);
      if (tb_if.led_go === 1'b1 || tb_if.result_valid === 1'b1 || tb_if.busy !== 1'b1) seen = 1'b1;
    end
    n_checks++;
    if (seen) begin
      n_fail++;
      $display("FAIL held_arm: got activity=%0b expected 0", seen);
    end
    tb_if.button = 1'b0;
    wait_led(cnt);
    n_checks++;
    if (cnt !== 13) begin
      n_fail++;
      $display("FAIL held_release_delay: got %0d expected 13", cnt);
    end
    wait_result(cnt);
    n_checks++;
    if (cnt !== 84) begin
      n_fail++;
      $display("FAIL held_timeout_len: got %0d expected 84", cnt);
    end
    @(negedge clk);
    sb_q.push_back(mk(3, 0, 0));
    wait_led(cnt);
    press_at(13);
    @(negedge clk);
    n_checks++;
    if (tb_if.done !== 1'b1 || tb_if.best_ms !== 10'd0) begin
      n_fail++;
      $display("FAIL held_session_end: got done=%0b best=%0d expected 1 0", tb_if.done, tb_if.best_ms);
    end
  endtask

  task automatic test_async_reset();
    int cnt;
    sb_q.push_back(mk(1, 0, 0));
    pulse_start();
    wait_led(cnt);
    press_at(6);
    @(negedge clk);
    wait_led(cnt);
    repeat (5) @(negedge clk);
    n_checks++;
    if (tb_if.led_go !== 1'b1 || tb_if.round_idx !== 3'd1) begin
      n_fail++;
      $display("FAIL pre_reset_go: got led=%0b round=%0d expected 1 1", tb_if.led_go, tb_if.round_idx);
    end
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if (tb_if.led_go !== 1'b0 || tb_if.busy !== 1'b0 || tb_if.best_ms !== 10'h3FF ||
        tb_if.reaction_ms !== 10'd0 || tb_if.round_idx !== 3'd0) begin
      n_fail++;
      $display("FAIL async_reset: got led=%0b busy=%0b best=%0h reaction=%0d round=%0d expected 0 0 3ff 0 0",
               tb_if.led_go, tb_if.busy, tb_if.best_ms, tb_if.reaction_ms, tb_if.round_idx);
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (tb_if.busy !== 1'b0 || tb_if.led_go !== 1'b0 || tb_if.done !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_idle: got busy=%0b led=%0b done=%0b expected 0 0 0", tb_if.busy, tb_if.led_go, tb_if.done);
    end
  endtask

  initial begin
    tb_if.start  = 1'b0;
    tb_if.button = 1'b0;
    reset        = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    test_reset();
    test_nominal();
    test_timeout();
    test_false_start();
    test_session_best();
    test_busy_start();
    test_held_button();
    test_async_reset();
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_leftover: got %0d pending results expected 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
